// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-cycle control unit: instruction class and
// branch condition codes, FSM state encoding, instruction field positions,
// the decoded datapath-control bundle and a 4-bit immediate sign-extender.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Instruction classes, IR[15:14]
    localparam logic [1:0] CLS_REG = 2'b00;
    localparam logic [1:0] CLS_IMM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    // Branch conditions, IR[13:12]
    localparam logic [1:0] COND_AL = 2'b00;
    localparam logic [1:0] COND_Z  = 2'b01;
    localparam logic [1:0] COND_N  = 2'b10;
    localparam logic [1:0] COND_C  = 2'b11;

    // Instruction field positions
    localparam int CLS_HI  = 15;
    localparam int CLS_LO  = 14;
    localparam int OP_HI   = 13;
    localparam int OP_LO   = 10;
    localparam int W_HI    = 9;
    localparam int W_LO    = 7;
    localparam int R_HI    = 6;
    localparam int R_LO    = 4;
    localparam int S_HI    = 3;
    localparam int S_LO    = 1;
    localparam int IMM_HI  = 3;
    localparam int IMM_LO  = 0;
    localparam int COND_HI = 13;
    localparam int COND_LO = 12;
    localparam int OFF_HI  = 7;
    localparam int OFF_LO  = 0;
    localparam int HALT_BIT = 13;   // class 11: 0 = NOP, 1 = HALT

    // Datapath control bundle produced by the decoder
    typedef struct packed {
        logic [3:0]  alu_op;
        logic [2:0]  w_adr;
        logic [2:0]  r_adr;
        logic [2:0]  s_adr;
        logic [15:0] ds;
        logic        s_sel;
    } ctrl_t;

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// -----------------------------------------------------------------------------
// cpu_control_unit_if
// Bundles the instruction-fetch handshake (Fetch_Req/Fetch_Adr/Fetch_Ack/IR_In),
// the datapath flags (N/Z/C) and the datapath controls (W_En, ALU_OP, W_Adr,
// R_Adr, S_Adr, DS, S_Sel).
//   master : control unit side (drives fetch request and datapath controls)
//   slave  : memory/datapath side (drives ack, instruction word and flags)
// -----------------------------------------------------------------------------
interface cpu_control_unit_if #(
    parameter int PC_W = 8
);
    logic            Fetch_Req;
    logic [PC_W-1:0] Fetch_Adr;
    logic            Fetch_Ack;
    logic [15:0]     IR_In;
    logic            N;
    logic            Z;
    logic            C;
    logic            W_En;
    logic [3:0]      ALU_OP;
    logic [2:0]      W_Adr;
    logic [2:0]      R_Adr;
    logic [2:0]      S_Adr;
    logic [15:0]     DS;
    logic            S_Sel;

    modport master (
        output Fetch_Req, Fetch_Adr, W_En, ALU_OP, W_Adr, R_Adr, S_Adr, DS, S_Sel,
        input  Fetch_Ack, IR_In, N, Z, C
    );

    modport slave (
        input  Fetch_Req, Fetch_Adr, W_En, ALU_OP, W_Adr, R_Adr, S_Adr, DS, S_Sel,
        output Fetch_Ack, IR_In, N, Z, C
    );
endinterface

// File: rtl/cpu_control_unit_instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational decode of the registered instruction word.
//   ir_i        in  16  instruction register
//   ctrl_o      out     datapath controls (zero for branch/system classes)
//   is_alu_o    out  1  class 00 or 01 (writes a register, updates flags)
//   is_branch_o out  1  class 10
//   is_halt_o   out  1  class 11 with HALT bit set
//   cond_o      out  2  branch condition
//   offset_o    out  8  signed branch offset
// -----------------------------------------------------------------------------
module instr_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output ctrl_t       ctrl_o,
    output logic        is_alu_o,
    output logic        is_branch_o,
    output logic        is_halt_o,
    output logic [1:0]  cond_o,
    output logic [7:0]  offset_o
);

    always_comb begin
        ctrl_o      = '0;
        is_alu_o    = 1'b0;
        is_branch_o = 1'b0;
        is_halt_o   = 1'b0;
        cond_o      = COND_AL;
        offset_o    = '0;
        unique case (ir_i[CLS_HI:CLS_LO])
            CLS_REG: begin
                ctrl_o.alu_op = ir_i[OP_HI:OP_LO];
                ctrl_o.w_adr  = ir_i[W_HI:W_LO];
                ctrl_o.r_adr  = ir_i[R_HI:R_LO];
                ctrl_o.s_adr  = ir_i[S_HI:S_LO];
                is_alu_o      = 1'b1;
            end
            CLS_IMM: begin
                ctrl_o.alu_op = ir_i[OP_HI:OP_LO];
                ctrl_o.w_adr  = ir_i[W_HI:W_LO];
                ctrl_o.r_adr  = ir_i[R_HI:R_LO];
                ctrl_o.ds     = sext4(ir_i[IMM_HI:IMM_LO]);
                ctrl_o.s_sel  = 1'b1;
                is_alu_o      = 1'b1;
            end
            CLS_BR: begin
                is_branch_o = 1'b1;
                cond_o      = ir_i[COND_HI:COND_LO];
                offset_o    = ir_i[OFF_HI:OFF_LO];
            end
            default: begin
                is_halt_o = ir_i[HALT_BIT];
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// -----------------------------------------------------------------------------
// cpu_control_unit
// Multi-cycle control unit: INIT -> FETCH -> DECODE -> EXECUTE -> FETCH, with
// HALT absorbing until reset. Fetches over a req/ack handshake, drives the
// register-file/ALU controls and keeps the N/Z/C flags of the last ALU op for
// conditional branches.
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-high reset
//   bus     ifc  master side of cpu_control_unit_if (fetch + datapath)
//   Halted  out  high while in HALT
// -----------------------------------------------------------------------------
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    cpu_control_unit_if.master  bus,
    output logic                Halted
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [2:0]      flags_q, flags_d;   // {N, Z, C}

    ctrl_t             dec_ctrl;
    logic              is_alu, is_branch, is_halt;
    logic [1:0]        cond;
    logic signed [7:0] offset;
    logic              taken;
    logic              active;

    instr_decode u_decode (
        .ir_i        (ir_q),
        .ctrl_o      (dec_ctrl),
        .is_alu_o    (is_alu),
        .is_branch_o (is_branch),
        .is_halt_o   (is_halt),
        .cond_o      (cond),
        .offset_o    (offset)
    );

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_AL: taken = 1'b1;
            COND_Z:  taken = flags_q[1];
            COND_N:  taken = flags_q[2];
            COND_C:  taken = flags_q[0];
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        unique case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.Fetch_Ack) begin
                    ir_d    = bus.IR_In;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_alu) begin
                    flags_d = {bus.N, bus.Z, bus.C};
                end
                // PC already points past the branch; the size cast sign-extends
                // the offset so the add wraps modulo 2^PC_W.
                if (is_branch && taken) begin
                    pc_d = pc_q + PC_W'(offset);
                end
                state_d = is_halt ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Controls are only presented while the instruction is in flight, so the
    // stale IR never leaks onto the datapath during FETCH/INIT/HALT.
    assign active = (state_q == ST_DECODE) || (state_q == ST_EXECUTE);

    assign bus.Fetch_Req = (state_q == ST_FETCH);
    assign bus.Fetch_Adr = pc_q;
    assign bus.W_En      = (state_q == ST_EXECUTE) && is_alu;
    assign bus.ALU_OP    = active ? dec_ctrl.alu_op : '0;
    assign bus.W_Adr     = active ? dec_ctrl.w_adr  : '0;
    assign bus.R_Adr     = active ? dec_ctrl.r_adr  : '0;
    assign bus.S_Adr     = active ? dec_ctrl.s_adr  : '0;
    assign bus.DS        = active ? dec_ctrl.ds     : '0;
    assign bus.S_Sel     = active ? dec_ctrl.s_sel  : 1'b0;
    assign Halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_unit
// Self-checking bench for cpu_control_unit: directed vector table, randomized
// instruction stream against an instruction-level reference model, and
// hand-written branch / wrap / halt / reset-in-EXECUTE sequences.
// -----------------------------------------------------------------------------
module tb_cpu_control_unit;

    logic clk = 1'b0;
    logic reset;
    logic Halted;

    always #5 clk = ~clk;

    cpu_control_unit_if #(.PC_W(8)) bus ();

    cpu_control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .Halted (Halted)
    );

    typedef struct {
        logic [3:0]  alu_op;
        logic [2:0]  w;
        logic [2:0]  r;
        logic [2:0]  s;
        logic [15:0] ds;
        logic        ssel;
        logic        wen;
    } exp_t;

    typedef struct {
        logic [15:0] ir;
        int          delay;
        logic [2:0]  nzc;
        exp_t        e;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         mpc;        // model program counter
    logic [2:0] mflags;     // model {N,Z,C}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Instruction-level view of what the datapath controls must be.
    function automatic exp_t model_ctrl(input logic [15:0] instr);
        exp_t e;
        int   i;
        int   cls;
        int   v;
        e   = '{4'd0, 3'd0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b0};
        i   = int'(instr);
        cls = i / 16384;
        if (cls < 2) begin
            e.alu_op = 4'((i / 1024) % 16);
            e.w      = 3'((i / 128) % 8);
            e.r      = 3'((i / 16) % 8);
            e.wen    = 1'b1;
            if (cls == 0) begin
                e.s = 3'((i / 2) % 8);
            end else begin
                v = i % 16;
                if (v >= 8) v = v - 16;
                e.ds   = 16'(v);
                e.ssel = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic model_update(input logic [15:0] instr, input logic [2:0] nzc);
        int i;
        int cls;
        int off;
        bit tk;
        i   = int'(instr);
        cls = i / 16384;
        off = 0;
        tk  = 1'b0;
        if (cls < 2) mflags = nzc;
        if (cls == 2) begin
            case ((i / 4096) % 4)
                0:       tk = 1'b1;
                1:       tk = mflags[1];
                2:       tk = mflags[2];
                default: tk = mflags[0];
            endcase
            off = i % 256;
            if (off >= 128) off = off - 256;
        end
        mpc = (mpc + 1 + (tk ? off : 0) + 256) % 256;
    endtask

    task automatic chk_ctrl(input string tag, input exp_t e);
        chk({tag, "_alu_op"}, 32'(bus.ALU_OP), 32'(e.alu_op));
        chk({tag, "_w_adr"},  32'(bus.W_Adr),  32'(e.w));
        chk({tag, "_r_adr"},  32'(bus.R_Adr),  32'(e.r));
        chk({tag, "_s_adr"},  32'(bus.S_Adr),  32'(e.s));
        chk({tag, "_ds"},     32'(bus.DS),     32'(e.ds));
        chk({tag, "_s_sel"},  32'(bus.S_Sel),  32'(e.ssel));
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after
    // EXECUTE (FETCH or HALT).
    task automatic exec_instr(input logic [15:0] instr, input int delay,
                              input logic [2:0] nzc, input exp_t e, input int adr);
        chk("fetch_req", 32'(bus.Fetch_Req), 32'd1);
        for (int d = 0; d < delay; d++) begin
            bus.Fetch_Ack = 1'b0;
            bus.IR_In     = 16'($urandom);
            tick();
            chk("wait_req", 32'(bus.Fetch_Req), 32'd1);
            chk("wait_adr", 32'(bus.Fetch_Adr), 32'(adr));
        end
        chk("fetch_adr", 32'(bus.Fetch_Adr), 32'(adr));
        bus.Fetch_Ack = 1'b1;
        bus.IR_In     = instr;
        tick();
        // Ack and IR_In are noise outside FETCH.
        bus.Fetch_Ack = 1'($urandom);
        bus.IR_In     = 16'($urandom);
        {bus.N, bus.Z, bus.C} = nzc;
        chk("dec_req", 32'(bus.Fetch_Req), 32'd0);
        chk("dec_wen", 32'(bus.W_En), 32'd0);
        chk_ctrl("dec", e);
        tick();
        bus.Fetch_Ack = 1'($urandom);
        chk("exe_wen", 32'(bus.W_En), 32'(e.wen));
        chk_ctrl("exe", e);
        tick();
        bus.Fetch_Ack = 1'b0;
        model_update(instr, nzc);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.Fetch_Ack = 1'b1;
        bus.IR_In     = 16'hFFFF;
        tick();
        tick();
        chk("rst_req",    32'(bus.Fetch_Req), 32'd0);
        chk("rst_wen",    32'(bus.W_En),      32'd0);
        chk("rst_halted", 32'(Halted),        32'd0);
        chk("rst_s_sel",  32'(bus.S_Sel),     32'd0);
        chk("rst_alu_op", 32'(bus.ALU_OP),    32'd0);
        chk("rst_ds",     32'(bus.DS),        32'd0);
        chk("rst_adr",    32'(bus.Fetch_Adr), 32'd0);
        reset = 1'b0;
        #1;
        chk("init_req", 32'(bus.Fetch_Req), 32'd0);
        chk("init_wen", 32'(bus.W_En),      32'd0);
        tick();
        chk("first_req", 32'(bus.Fetch_Req), 32'd1);
        chk("first_adr", 32'(bus.Fetch_Adr), 32'd0);
        mpc    = 0;
        mflags = 3'b000;
    endtask

    vec_t        vecs[8];
    exp_t        ez;
    logic [15:0] instr;
    logic [2:0]  nzc;
    int          off;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        ez = '{4'd0, 3'd0, 3'd0, 3'd0, 16'd0, 1'b0, 1'b0};
        vecs[0] = '{16'h0994, 0, 3'b000, '{4'd2,  3'd3, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b1}};
        vecs[1] = '{16'h409E, 0, 3'b001, '{4'd0,  3'd1, 3'd1, 3'd0, 16'hFFFE, 1'b1, 1'b1}};
        vecs[2] = '{16'h4C77, 1, 3'b010, '{4'd3,  3'd0, 3'd7, 3'd0, 16'h0007, 1'b1, 1'b1}};
        vecs[3] = '{16'h3FFE, 5, 3'b011, '{4'd15, 3'd7, 3'd7, 3'd7, 16'h0000, 1'b0, 1'b1}};
        vecs[4] = '{16'h8003, 2, 3'b111, '{4'd0,  3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0}};
        vecs[5] = '{16'hC000, 1, 3'b111, '{4'd0,  3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0}};
        vecs[6] = '{16'h5FF8, 0, 3'b100, '{4'd7,  3'd7, 3'd7, 3'd0, 16'hFFF8, 1'b1, 1'b1}};
        vecs[7] = '{16'hA002, 0, 3'b000, '{4'd0,  3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b0}};

        bus.Fetch_Ack = 1'b0;
        bus.IR_In     = 16'h0000;
        {bus.N, bus.Z, bus.C} = 3'b000;
        do_reset();

        // Directed table
        for (int k = 0; k < 8; k++) begin
            exec_instr(vecs[k].ir, vecs[k].delay, vecs[k].nzc, vecs[k].e, mpc);
        end
        // N latched by 0x5FF8, so 0xA002 at 0x0A lands on 0x0D.
        chk("tbl_br_n_adr", 32'(bus.Fetch_Adr), 32'h0D);

        // Randomized stream (no HALT)
        for (int k = 0; k < 80; k++) begin
            instr = 16'($urandom);
            if (instr[15:14] == 2'b11) instr[13] = 1'b0;
            nzc = 3'($urandom);
            exec_instr(instr, int'($urandom_range(0, 3)), nzc, model_ctrl(instr), mpc);
        end

        // Z=1, then jump to 0x10 and take BZ -3 -> 0x0E
        exec_instr(16'h0994, 0, 3'b010, model_ctrl(16'h0994), mpc);
        off   = ((16 - mpc - 1) % 256 + 256) % 256;
        instr = 16'h8000 | 16'(off);
        exec_instr(instr, 0, 3'b000, ez, mpc);
        exec_instr(16'h90FD, 0, 3'b111, ez, 32'h10);
        // Clear Z, NOP, BZ at 0x10 not taken -> 0x11
        exec_instr(16'h409E, 0, 3'b000, model_ctrl(16'h409E), 32'h0E);
        exec_instr(16'hC000, 0, 3'b111, ez, 32'h0F);
        exec_instr(16'h90FD, 0, 3'b111, ez, 32'h10);
        // Branch to 0xFF, fetch there, wrap to 0x00
        exec_instr(16'h80ED, 0, 3'b000, ez, 32'h11);
        exec_instr(16'hC000, 5, 3'b000, ez, 32'hFF);
        // HALT at 0x00
        exec_instr(16'hE000, 0, 3'b000, ez, 32'h00);
        for (int k = 0; k < 4; k++) begin
            bus.Fetch_Ack = 1'b1;
            chk("halt_halted", 32'(Halted),        32'd1);
            chk("halt_req",    32'(bus.Fetch_Req), 32'd0);
            chk("halt_wen",    32'(bus.W_En),      32'd0);
            tick();
        end

        // Reset in EXECUTE of 0x0994
        do_reset();
        bus.Fetch_Ack = 1'b1;
        bus.IR_In     = 16'h0994;
        tick();
        bus.Fetch_Ack = 1'b0;
        tick();
        chk("rx_wen_before", 32'(bus.W_En), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rx_wen_drop",  32'(bus.W_En),      32'd0);
        chk("rx_req",       32'(bus.Fetch_Req), 32'd0);
        chk("rx_alu_op",    32'(bus.ALU_OP),    32'd0);
        chk("rx_w_adr",     32'(bus.W_Adr),     32'd0);
        chk("rx_fetch_adr", 32'(bus.Fetch_Adr), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("rx_refetch_req", 32'(bus.Fetch_Req), 32'd1);
        chk("rx_refetch_adr", 32'(bus.Fetch_Adr), 32'd0);
        mpc    = 0;
        mflags = 3'b000;
        exec_instr(16'h409E, 0, 3'b001, vecs[1].e, mpc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
